// File: rtl/cpu_bus_wait_ctrl.sv
// cpu_bus_wait_ctrl
// Converts the CPU wrapper's one-cycle access strobe into a held
// valid/ready transaction on the peripheral bus and stalls the core
// (cpu_halt_o) until the slave answers or the wait times out. Read data is
// registered back to the CPU. A sticky flag records bus timeouts.
//
// Ports
//   clk_i, reset_i          clock, async active-high reset
//   cpu_req_i               one-cycle access strobe (qualifies addr/wdata/wstrb)
//   cpu_addr_i/wdata_i      access address and write data
//   cpu_wstrb_i             byte strobes, 0 = read
//   cpu_rdata_o             registered read data, held until next completed read
//   cpu_halt_o              stall to the wrapper while an access is in flight
//   bus_valid_o             transaction request to the bus
//   bus_addr/wdata/wstrb_o  latched access, stable while bus_valid_o is high
//   bus_we_o                latched write flag (OR of strobes)
//   bus_rdata_i/ready_i     slave response
//   err_clr_i, err_o        clear / sticky timeout flag
//
// state  | meaning
// IDLE   | no access in flight
// ACCESS | bus_valid_o and cpu_halt_o high, waiting for ready or timeout
// DONE   | single completion cycle, halt released, cpu_rdata_o valid

module cpu_bus_wait_ctrl #(
    parameter int unsigned address_width = 32,
    parameter int unsigned TimeoutCycles = 256,
    parameter logic [31:0] TimeoutData   = 32'hDEADBEEF
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cpu_req_i,
    input  logic [address_width-1:0] cpu_addr_i,
    input  logic [31:0]              cpu_wdata_i,
    input  logic [3:0]               cpu_wstrb_i,
    output logic [31:0]              cpu_rdata_o,
    output logic                     cpu_halt_o,
    output logic                     bus_valid_o,
    output logic [address_width-1:0] bus_addr_o,
    output logic [31:0]              bus_wdata_o,
    output logic [3:0]               bus_wstrb_o,
    output logic                     bus_we_o,
    input  logic [31:0]              bus_rdata_i,
    input  logic                     bus_ready_i,
    input  logic                     err_clr_i,
    output logic                     err_o
);

    localparam bit          TimeoutEn = (TimeoutCycles != 0);
    localparam int unsigned CntWidth  = TimeoutEn ? $clog2(TimeoutCycles + 1) : 1;
    // When the timeout is disabled this value is never compared against.
    localparam logic [CntWidth-1:0] CntLast = CntWidth'(TimeoutCycles - 1);
    localparam logic [CntWidth-1:0] CntMax  = '1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [CntWidth-1:0] cnt;
    logic                start;
    logic                ready_done;
    logic                timeout_done;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        start        = 1'b0;
        ready_done   = 1'b0;
        timeout_done = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (cpu_req_i) begin
                    start      = 1'b1;
                    state_next = ACCESS;
                end else begin
                    state_next = IDLE;
                end
            end
            ACCESS: begin
                // Ready has priority over a timeout landing in the same cycle.
                if (bus_ready_i) begin
                    ready_done = 1'b1;
                    state_next = DONE;
                end else if (TimeoutEn && (cnt == CntLast)) begin
                    timeout_done = 1'b1;
                    state_next   = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Wait counter: cleared at the start of each access, counts ACCESS cycles
    // without ready, saturates rather than wrapping.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if ((state == ACCESS) && !bus_ready_i && (cnt != CntMax)) begin
            cnt <= cnt + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cpu_halt_o  <= 1'b0;
            bus_valid_o <= 1'b0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            bus_wstrb_o <= '0;
            bus_we_o    <= 1'b0;
            cpu_rdata_o <= '0;
            err_o       <= 1'b0;
        end else begin
            cpu_halt_o  <= (state_next == ACCESS);
            bus_valid_o <= (state_next == ACCESS);

            if (start) begin
                bus_addr_o  <= cpu_addr_i;
                bus_wdata_o <= cpu_wdata_i;
                bus_wstrb_o <= cpu_wstrb_i;
                bus_we_o    <= |cpu_wstrb_i;
            end

            if (ready_done && !bus_we_o) begin
                cpu_rdata_o <= bus_rdata_i;
            end else if (timeout_done && !bus_we_o) begin
                cpu_rdata_o <= TimeoutData;
            end

            if (timeout_done) begin
                err_o <= 1'b1;
            end else if (err_clr_i) begin
                err_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_bus_wait_ctrl.sv
module tb_cpu_bus_wait_ctrl;

    localparam int          TO = 8;
    localparam logic [31:0] TD = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata_in = '0;
    logic        ready = 1'b0;
    logic        err_clr = 1'b0;

    logic [31:0] cpu_rdata;
    logic        cpu_halt;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_we;
    logic        err;

    int tests = 0;
    int fails = 0;

    cpu_bus_wait_ctrl #(
        .address_width(32),
        .TimeoutCycles(TO),
        .TimeoutData(TD)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .cpu_req_i(req),
        .cpu_addr_i(addr),
        .cpu_wdata_i(wdata),
        .cpu_wstrb_i(wstrb),
        .cpu_rdata_o(cpu_rdata),
        .cpu_halt_o(cpu_halt),
        .bus_valid_o(bus_valid),
        .bus_addr_o(bus_addr),
        .bus_wdata_o(bus_wdata),
        .bus_wstrb_o(bus_wstrb),
        .bus_we_o(bus_we),
        .bus_rdata_i(rdata_in),
        .bus_ready_i(ready),
        .err_clr_i(err_clr),
        .err_o(err)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: either an access is outstanding or not;
    // an outstanding access ends on ready or after TO unanswered cycles.
    bit          m_busy = 1'b0;
    int          m_waits = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0]  m_wstrb = '0;
    logic [31:0] m_rdata = '0;
    bit          m_err = 1'b0;
    bit          m_timeout_now;

    assign m_timeout_now = m_busy && !ready && (m_waits + 1 == TO);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy  <= 1'b0;
            m_waits <= 0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
            m_rdata <= '0;
            m_err   <= 1'b0;
        end else begin
            if (m_busy) begin
                if (ready) begin
                    m_busy <= 1'b0;
                    if (m_wstrb == 4'd0) m_rdata <= rdata_in;
                end else if (m_timeout_now) begin
                    m_busy <= 1'b0;
                    if (m_wstrb == 4'd0) m_rdata <= TD;
                end else begin
                    m_waits <= m_waits + 1;
                end
            end else if (req) begin
                m_busy  <= 1'b1;
                m_waits <= 0;
                m_addr  <= addr;
                m_wdata <= wdata;
                m_wstrb <= wstrb;
            end
            if (m_timeout_now) m_err <= 1'b1;
            else if (err_clr)  m_err <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("halt",  {31'd0, cpu_halt},  {31'd0, m_busy});
        chk("valid", {31'd0, bus_valid}, {31'd0, m_busy});
        chk("addr",  bus_addr,  m_addr);
        chk("wdata", bus_wdata, m_wdata);
        chk("wstrb", {28'd0, bus_wstrb}, {28'd0, m_wstrb});
        chk("we",    {31'd0, bus_we},    {31'd0, (m_wstrb != 4'd0)});
        chk("rdata", cpu_rdata, m_rdata);
        chk("err",   {31'd0, err},       {31'd0, m_err});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        req = 1'b0; ready = 1'b0; err_clr = 1'b0; wstrb = 4'd0;
    endtask

    task automatic start_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; addr = a; wdata = d; wstrb = s;
        tick();
        req = 1'b0;
    endtask

    task automatic async_reset_pulse();
        #2 reset = 1'b1;
        #1;
        chk("rst_halt",  {31'd0, cpu_halt},  32'd0);
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_err",   {31'd0, err},       32'd0);
        chk("rst_addr",  bus_addr, 32'd0);
        #1 reset = 1'b0;
    endtask

    initial begin
        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("init_halt",  {31'd0, cpu_halt},  32'd0);
        chk("init_valid", {31'd0, bus_valid}, 32'd0);
        chk("init_rdata", cpu_rdata, 32'd0);
        chk("init_err",   {31'd0, err},       32'd0);
        reset = 1'b0;
        tick();

        // read, zero wait
        start_access(32'h0000_1000, 32'h0, 4'b0000);
        chk("rd0_halt_c1", {31'd0, cpu_halt}, 32'd1);
        chk("rd0_addr_c1", bus_addr, 32'h0000_1000);
        ready = 1'b1; rdata_in = 32'hA5A5_0001;
        tick();
        chk("rd0_halt_c2",  {31'd0, cpu_halt},  32'd0);
        chk("rd0_valid_c2", {31'd0, bus_valid}, 32'd0);
        chk("rd0_rdata_c2", cpu_rdata, 32'hA5A5_0001);
        idle_inputs();
        tick();

        // write, 3 wait states, ready at cycle 4
        start_access(32'h0000_2000, 32'h1234_5678, 4'b0011);
        for (int c = 1; c <= 4; c++) begin
            chk("wr_halt",  {31'd0, cpu_halt}, 32'd1);
            chk("wr_we",    {31'd0, bus_we},   32'd1);
            chk("wr_wstrb", {28'd0, bus_wstrb}, 32'h3);
            chk("wr_wdata", bus_wdata, 32'h1234_5678);
            if (c == 4) ready = 1'b1;
            rdata_in = 32'hFFFF_0000;
            tick();
        end
        chk("wr_halt_c5",  {31'd0, cpu_halt}, 32'd0);
        chk("wr_rdata_c5", cpu_rdata, 32'hA5A5_0001);
        idle_inputs();
        tick();

        // timeout: no ready, DONE at cycle 9
        start_access(32'h0000_3000, 32'h0, 4'b0000);
        for (int c = 1; c <= 8; c++) begin
            chk("to_halt", {31'd0, cpu_halt}, 32'd1);
            tick();
        end
        chk("to_halt_c9",  {31'd0, cpu_halt}, 32'd0);
        chk("to_rdata_c9", cpu_rdata, 32'hDEADBEEF);
        chk("to_err_c9",   {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        tick();
        chk("to_err_clr", {31'd0, err}, 32'd0);
        idle_inputs();
        tick();

        // ready exactly in the timeout cycle
        start_access(32'h0000_4000, 32'h0, 4'b0000);
        for (int c = 1; c <= 8; c++) begin
            if (c == 8) begin ready = 1'b1; rdata_in = 32'h55; end
            tick();
        end
        chk("rt_halt",  {31'd0, cpu_halt}, 32'd0);
        chk("rt_rdata", cpu_rdata, 32'h55);
        chk("rt_err",   {31'd0, err}, 32'd0);
        idle_inputs();
        tick();

        // back-to-back
        start_access(32'h0000_5000, 32'h0, 4'b0000);
        ready = 1'b1; rdata_in = 32'h1111_2222;
        tick();
        chk("b2b_done_valid", {31'd0, bus_valid}, 32'd0);
        ready = 1'b0;
        start_access(32'h0000_6000, 32'h0, 4'b0000);
        chk("b2b_valid", {31'd0, bus_valid}, 32'd1);
        chk("b2b_addr",  bus_addr, 32'h0000_6000);
        ready = 1'b1; rdata_in = 32'h3333_4444;
        tick();
        chk("b2b_rdata", cpu_rdata, 32'h3333_4444);
        idle_inputs();
        tick();

        // reset during the 2nd wait cycle, then a fresh read
        start_access(32'h0000_7000, 32'h0, 4'b0000);
        tick();
        async_reset_pulse();
        tick();
        start_access(32'h0000_8000, 32'h0, 4'b0000);
        ready = 1'b1; rdata_in = 32'hCAFE_0008;
        tick();
        chk("post_rst_rdata", cpu_rdata, 32'hCAFE_0008);
        chk("post_rst_halt",  {31'd0, cpu_halt}, 32'd0);
        idle_inputs();
        tick();

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            bit slow;
            slow     = ((i / 80) % 2) == 1;
            req      = ($urandom_range(0, 2) == 0);
            addr     = $urandom;
            wdata    = $urandom;
            wstrb    = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
            rdata_in = $urandom;
            ready    = slow ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 1) == 1);
            err_clr  = ($urandom_range(0, 9) == 0);
            if ((i % 149) == 148) async_reset_pulse();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
